// File: rtl/multicycle_control_if.sv
// ----------------------------------------------------------------------------
// multicycle_control_if
// Bundles the signals between the multi-cycle control sequencer and the
// shared datapath / instruction memory.
//   Into the sequencer : instr_valid, instr[31:0], EQ
//   Out of the sequencer: IRwrite, ImmSrc[1:0], ALUsrc, ALUctrl[2:0],
//                         RegWrite, PCwrite, PCsrc, halted,
//                         retired[CNT_W-1:0], state[2:0]
// slave  : the sequencer's view.
// master : the datapath / memory side, which drives instructions and flags.
// ----------------------------------------------------------------------------
interface multicycle_control_if #(
   parameter int CNT_W = 16
);
   logic             instr_valid;
   logic [31:0]      instr;
   logic             EQ;
   logic             IRwrite;
   logic [1:0]       ImmSrc;
   logic             ALUsrc;
   logic [2:0]       ALUctrl;
   logic             RegWrite;
   logic             PCwrite;
   logic             PCsrc;
   logic             halted;
   logic [CNT_W-1:0] retired;
   logic [2:0]       state;

   modport slave (
      input  instr_valid, instr, EQ,
      output IRwrite, ImmSrc, ALUsrc, ALUctrl, RegWrite, PCwrite, PCsrc,
             halted, retired, state
   );

   modport master (
      output instr_valid, instr, EQ,
      input  IRwrite, ImmSrc, ALUsrc, ALUctrl, RegWrite, PCwrite, PCsrc,
             halted, retired, state
   );
endinterface

// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control
// Control sequencer for a reduced RISC-V core with one shared datapath.
// Steps each instruction through FETCH / DECODE / EXEC / WB (addi) or
// FETCH / DECODE / BRANCH (bne); any other encoding parks the FSM in TRAP
// until reset. Counts retired instructions in a wrapping CNT_W-bit counter.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - multicycle_control_if.slave (instruction in, EQ flag in,
//          datapath controls, halted, retired count, debug state out)
// ----------------------------------------------------------------------------
module multicycle_control #(
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   multicycle_control_if.slave  bus
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_WB     = 3'd3,
      S_BRANCH = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic [31:0]      ir_q, ir_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             halted_q, halted_d;

   // Decode always works from the captured IR, never the live instr bus.
   logic is_addi, is_bne;
   assign is_addi = (ir_q[6:0] == 7'b0010011) && (ir_q[14:12] == 3'b000);
   assign is_bne  = (ir_q[6:0] == 7'b1100011) && (ir_q[14:12] == 3'b001);

   // Register/immediate fields are consumed by the datapath, not here.
   logic unused_ir_fields;
   assign unused_ir_fields = ^{ir_q[31:15], ir_q[11:7]};

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      ir_d      = ir_q;
      retired_d = retired_q;
      halted_d  = halted_q;
      case (state_q)
         S_FETCH: begin
            if (bus.instr_valid) begin
               ir_d    = bus.instr;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (is_addi) begin
               state_d = S_EXEC;
            end else if (is_bne) begin
               state_d = S_BRANCH;
            end else begin
               state_d  = S_TRAP;
               halted_d = 1'b1;
            end
         end
         S_EXEC: state_d = S_WB;
         S_WB, S_BRANCH: begin
            retired_d = retired_q + 1'b1;   // wraps silently
            state_d   = S_FETCH;
         end
         S_TRAP: begin
            state_d  = S_TRAP;
            halted_d = 1'b1;
         end
         default: state_d = S_FETCH;        // unused encodings recover
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         ir_q      <= 32'd0;
         retired_q <= '0;
         halted_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         retired_q <= retired_d;
         halted_q  <= halted_d;
      end
   end

   // Moore outputs from state/IR. Only IRwrite (instr_valid) and PCsrc (EQ)
   // see an input combinationally.
   always_comb begin
      bus.IRwrite  = 1'b0;
      bus.ImmSrc   = 2'b00;
      bus.ALUsrc   = 1'b0;
      bus.ALUctrl  = 3'b000;
      bus.RegWrite = 1'b0;
      bus.PCwrite  = 1'b0;
      bus.PCsrc    = 1'b0;
      case (state_q)
         S_FETCH:  bus.IRwrite = bus.instr_valid;
         S_DECODE: bus.ImmSrc  = is_bne ? 2'b01 : 2'b00;
         S_EXEC:   bus.ALUsrc  = 1'b1;
         S_WB: begin
            bus.ALUsrc   = 1'b1;
            bus.RegWrite = 1'b1;
            bus.PCwrite  = 1'b1;
         end
         S_BRANCH: begin
            bus.ImmSrc  = 2'b01;
            bus.ALUctrl = 3'b001;
            bus.PCwrite = 1'b1;
            bus.PCsrc   = ~bus.EQ;
         end
         default: ;
      endcase
   end

   assign bus.halted  = halted_q;
   assign bus.retired = retired_q;
   assign bus.state   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

   localparam logic [31:0] ADDI = 32'h00500093;
   localparam logic [31:0] BNE  = 32'h00209463;
   localparam logic [31:0] ILL  = 32'h00000033;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   multicycle_control_if #(.CNT_W(4)) bus ();
   multicycle_control #(.CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct packed {
      logic        r;
      logic        iv;
      logic [31:0] ins;
      logic        eq;
   } stim_t;

   stim_t       st_q[$];
   logic [17:0] sb_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [3:0]  r_m   = 4'd0;

   // {state, IRwrite, ImmSrc, ALUsrc, ALUctrl, RegWrite, PCwrite, PCsrc, halted, retired}
   function automatic logic [17:0] pk(logic [2:0] s, logic irw, logic [1:0] imm, logic asrc,
                                      logic [2:0] actl, logic rw, logic pcw, logic pcs,
                                      logic h, logic [3:0] ret);
      return {s, irw, imm, asrc, actl, rw, pcw, pcs, h, ret};
   endfunction

   function automatic logic [17:0] x_fetch(logic iv, logic [3:0] r);
      return pk(3'd0, iv, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, r);
   endfunction
   function automatic logic [17:0] x_dec(logic [1:0] imm, logic [3:0] r);
      return pk(3'd1, 1'b0, imm, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, r);
   endfunction
   function automatic logic [17:0] x_exec(logic [3:0] r);
      return pk(3'd2, 1'b0, 2'b00, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, r);
   endfunction
   function automatic logic [17:0] x_wb(logic [3:0] r);
      return pk(3'd3, 1'b0, 2'b00, 1'b1, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, r);
   endfunction
   function automatic logic [17:0] x_br(logic pcs, logic [3:0] r);
      return pk(3'd4, 1'b0, 2'b01, 1'b0, 3'b001, 1'b0, 1'b1, pcs, 1'b0, r);
   endfunction
   function automatic logic [17:0] x_trap(logic [3:0] r);
      return pk(3'd5, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, r);
   endfunction

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic push(input logic r, input logic iv, input logic [31:0] ins,
                       input logic eq, input logic [17:0] e);
      stim_t c;
      c = '{r: r, iv: iv, ins: ins, eq: eq};
      st_q.push_back(c);
      sb_q.push_back(e);
   endtask

   task automatic drive(input stim_t c, output logic [17:0] o);
      @(negedge clk);
      rst             = c.r;
      bus.instr_valid = c.iv;
      bus.instr       = c.ins;
      bus.EQ          = c.eq;
      #1;
      o = {bus.state, bus.IRwrite, bus.ImmSrc, bus.ALUsrc, bus.ALUctrl,
           bus.RegWrite, bus.PCwrite, bus.PCsrc, bus.halted, bus.retired};
   endtask

   // hold=1 keeps instr_valid high through every phase
   task automatic push_addi(input logic hold);
      push(1'b0, 1'b1, ADDI, rbit(), x_fetch(1'b1, r_m));
      push(1'b0, hold | rbit(), $urandom, rbit(), x_dec(2'b00, r_m));
      push(1'b0, hold | rbit(), $urandom, rbit(), x_exec(r_m));
      push(1'b0, hold | rbit(), $urandom, rbit(), x_wb(r_m));
      r_m = r_m + 4'd1;
   endtask

   task automatic push_bne(input logic eq);
      push(1'b0, 1'b1, BNE, rbit(), x_fetch(1'b1, r_m));
      push(1'b0, rbit(), $urandom, rbit(), x_dec(2'b01, r_m));
      push(1'b0, rbit(), $urandom, eq, x_br(~eq, r_m));
      r_m = r_m + 4'd1;
   endtask

   task automatic test_reset();
      stim_t c;
      logic [17:0] o, e;
      c = '{r: 1'b1, iv: 1'b0, ins: 32'd0, eq: 1'b0};
      drive(c, o);
      drive(c, o);
      r_m = 4'd0;
      push(1'b0, 1'b0, ILL, 1'b1, x_fetch(1'b0, r_m));
      push(1'b0, 1'b0, ADDI, 1'b0, x_fetch(1'b0, r_m));
      while (st_q.size() > 0) begin
         c = st_q.pop_front(); e = sb_q.pop_front(); drive(c, o); n_cmp++;
         if (o !== e) begin n_err++; $display("FAIL reset: got %h expected %h", o, e); end
      end
   endtask

   task automatic test_addi();
      stim_t c;
      logic [17:0] o, e;
      push_addi(1'b0);
      push(1'b0, 1'b0, 32'd0, 1'b0, x_fetch(1'b0, r_m));
      while (st_q.size() > 0) begin
         c = st_q.pop_front(); e = sb_q.pop_front(); drive(c, o); n_cmp++;
         if (o !== e) begin n_err++; $display("FAIL addi: got %h expected %h", o, e); end
      end
   endtask

   task automatic test_bne();
      stim_t c;
      logic [17:0] o, e;
      push_bne(1'b0);
      push_bne(1'b1);
      push(1'b0, 1'b0, 32'd0, 1'b0, x_fetch(1'b0, r_m));
      while (st_q.size() > 0) begin
         c = st_q.pop_front(); e = sb_q.pop_front(); drive(c, o); n_cmp++;
         if (o !== e) begin n_err++; $display("FAIL bne: got %h expected %h", o, e); end
      end
   endtask

   task automatic test_stall();
      stim_t c;
      logic [17:0] o, e;
      for (int i = 0; i < 5; i++) push(1'b0, 1'b0, $urandom, rbit(), x_fetch(1'b0, r_m));
      push_addi(1'b0);
      while (st_q.size() > 0) begin
         c = st_q.pop_front(); e = sb_q.pop_front(); drive(c, o); n_cmp++;
         if (o !== e) begin n_err++; $display("FAIL stall: got %h expected %h", o, e); end
      end
   endtask

   task automatic test_illegal();
      stim_t c;
      logic [17:0] o, e;
      push(1'b0, 1'b1, ILL, rbit(), x_fetch(1'b1, r_m));
      push(1'b0, rbit(), ADDI, rbit(), x_dec(2'b00, r_m));
      for (int i = 0; i < 10; i++) push(1'b0, rbit(), ADDI, rbit(), x_trap(r_m));
      push(1'b1, 1'b1, ADDI, rbit(), x_trap(r_m));   // reset edge ends the trap
      r_m = 4'd0;
      push(1'b0, 1'b0, ADDI, 1'b0, x_fetch(1'b0, r_m));
      while (st_q.size() > 0) begin
         c = st_q.pop_front(); e = sb_q.pop_front(); drive(c, o); n_cmp++;
         if (o !== e) begin n_err++; $display("FAIL illegal: got %h expected %h", o, e); end
      end
   endtask

   task automatic test_reset_mid();
      stim_t c;
      logic [17:0] o, e;
      push_bne(rbit());
      push(1'b0, 1'b1, ADDI, 1'b0, x_fetch(1'b1, r_m));
      push(1'b0, 1'b0, 32'd0, 1'b0, x_dec(2'b00, r_m));
      push(1'b1, 1'b0, 32'd0, 1'b0, x_exec(r_m));     // reset lands while in EXEC
      r_m = 4'd0;
      for (int i = 0; i < 3; i++) push(1'b0, 1'b0, ADDI, 1'b0, x_fetch(1'b0, r_m));
      while (st_q.size() > 0) begin
         c = st_q.pop_front(); e = sb_q.pop_front(); drive(c, o); n_cmp++;
         if (o !== e) begin n_err++; $display("FAIL reset_mid: got %h expected %h", o, e); end
      end
   endtask

   task automatic test_back_to_back();
      stim_t c;
      logic [17:0] o, e;
      int cyc  = 0;
      int span = -1;
      for (int i = 0; i < 16; i++) push_addi(1'b1);
      push(1'b0, 1'b0, 32'd0, 1'b0, x_fetch(1'b0, r_m));
      while (st_q.size() > 0) begin
         c = st_q.pop_front(); e = sb_q.pop_front(); drive(c, o); n_cmp++; cyc++;
         if (o !== e) begin n_err++; $display("FAIL back_to_back: got %h expected %h", o, e); end
         if (span < 0 && cyc > 1 && o[17:15] == 3'd0 && o[3:0] == 4'd0) span = cyc - 1;
      end
      n_cmp++;
      if (span !== 64) begin
         n_err++;
         $display("FAIL b2b_cycles: got %0d cycles expected 64", span);
      end
   endtask

   initial begin
      bus.instr_valid = 1'b0;
      bus.instr       = 32'd0;
      bus.EQ          = 1'b0;
      test_reset();
      test_addi();
      test_bne();
      test_stall();
      test_illegal();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle control sequencer for the reduced RISC-V core. It sequences one shared datapath (register file, sign-extend unit, ALU, PC register) through fetch, decode, execute and write-back phases. It supports `addi` and `bne`. It drives the sign-extend unit's `ImmSrc` select together with the ALU, register-file and PC controls. It counts retired instructions and halts on any unsupported encoding.

## Interface
Parameters:
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clk`, input, 1: single system clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous reset, active-high.
- `instr_valid`, input, 1: instruction memory output `instr` is valid this cycle.
- `instr`, input, 32: fetched instruction word.
- `EQ`, input, 1: ALU equality flag; 1 when operands are equal.
- `IRwrite`, output, 1: capture strobe for the internal instruction register (IR), exported for the datapath.
- `ImmSrc`, output, 2: sign-extend format select. 00 = I-type, 01 = B-type.
- `ALUsrc`, output, 1: ALU operand B select. 1 = immediate, 0 = rs2.
- `ALUctrl`, output, 3: ALU operation. 000 = add, 001 = subtract.
- `RegWrite`, output, 1: register-file write enable.
- `PCwrite`, output, 1: PC update enable.
- `PCsrc`, output, 1: next-PC select. 0 = PC+4, 1 = PC+imm.
- `halted`, output, 1: sticky trap indicator.
- `retired`, output, `CNT_W`: count of completed instructions.
- `state`, output, 3: current FSM state encoding, for debug.

## Operation
- Internal 32-bit IR, loaded from `instr` only in FETCH when `instr_valid` = 1. All decoding uses IR, never the live `instr` input.
- Decode classes:
  - ADDI: opcode 0010011, funct3 000.
  - BNE: opcode 1100011, funct3 001.
  - Anything else: ILLEGAL.
- States and encodings: FETCH = 0, DECODE = 1, EXEC = 2, WB = 3, BRANCH = 4, TRAP = 5. Encodings 6 and 7 are unused and go to FETCH on the next cycle.
- FETCH:
  - `IRwrite` = `instr_valid`.
  - If `instr_valid` = 1, go to DECODE; otherwise stay in FETCH.
- DECODE:
  - `ImmSrc` set from the IR class.
  - ADDI goes to EXEC, BNE goes to BRANCH, ILLEGAL goes to TRAP.
- EXEC: `ALUsrc` = 1, `ALUctrl` = 000, `ImmSrc` = 00. Go to WB.
- WB:
  - `ALUsrc` = 1, `ALUctrl` = 000, `ImmSrc` = 00.
  - `RegWrite` = 1, `PCwrite` = 1, `PCsrc` = 0.
  - Increment `retired`; go to FETCH.
- BRANCH:
  - `ALUsrc` = 0, `ALUctrl` = 001, `ImmSrc` = 01.
  - `PCwrite` = 1, `PCsrc` = ~`EQ`.
  - Increment `retired`; go to FETCH.
- TRAP:
  - All enables are 0 and `halted` = 1.
  - Remains in TRAP until `rst`; `instr_valid` is ignored.
- Default for every output not listed in a state: 0.
- `ImmSrc` in FETCH and TRAP is 00.
- `retired` wraps from 2^CNT_W−1 to 0 with no flag.
- An ILLEGAL instruction does not increment `retired`.
- `RegWrite` asserts even when rd = x0; the register file is responsible for discarding x0 writes.

## Timing
- Outputs are Moore-style: combinational from the state register and IR only. There is no path from `instr`/`instr_valid` to any output except `IRwrite`.
- Exception: `PCsrc` in BRANCH depends combinationally on `EQ`, which is sampled in that same cycle.
- Latency, counting from the cycle `instr_valid` is first seen high in FETCH:
  - ADDI: 4 cycles (FETCH, DECODE, EXEC, WB).
  - BNE: 3 cycles (FETCH, DECODE, BRANCH).
  - Illegal: 2 cycles to reach TRAP.
- Back-to-back issue: the next FETCH immediately follows WB/BRANCH. With `instr_valid` held high, the sustained rates are 4 cycles per ADDI and 3 cycles per BNE.
- Reset:
  - `rst` = 1 at an edge forces state = FETCH, IR = 0, `retired` = 0, `halted` = 0.
  - All outputs are 0 in the cycle after reset, except `IRwrite`, which follows `instr_valid`.
  - Reset overrides every state, including mid-instruction: a WB interrupted by reset produces no write and no count.
- `instr_valid` low while in FETCH: stall indefinitely with all enables 0.
- `retired` updates on the same edge that leaves WB/BRANCH and is visible in the following FETCH cycle.

## Test plan
- Reset, then ADDI 0x00500093 with `instr_valid` = 1 → `state` sequence 0,1,2,3,0. In WB: `RegWrite` = 1, `PCwrite` = 1, `PCsrc` = 0, `ALUsrc` = 1, `ImmSrc` = 00. `retired` = 1 afterwards.
- BNE 0x00209463:
  - with `EQ` = 0 in BRANCH → `PCwrite` = 1, `PCsrc` = 1, `ALUctrl` = 001, `ImmSrc` = 01, `RegWrite` = 0.
  - repeated with `EQ` = 1 → `PCsrc` = 0. `retired` increments by 1 each time.
- Hold `instr_valid` = 0 for 5 cycles in FETCH → `state` stays 0, all enables 0, IR unchanged. Then raise `instr_valid` → DECODE on the next edge.
- Illegal word 0x00000033 → `state` 0,1,5. `halted` = 1 for the following 10 cycles regardless of `instr_valid`. `retired` unchanged. Reset clears `halted` and returns to FETCH.
- Assert `rst` during EXEC of an ADDI → next `state` = 0, `RegWrite` never asserts, `retired` = 0.
- With `CNT_W` = 4, retire 16 ADDIs back-to-back → `retired` reads 15, then 0. Total cycle count = 64.
